// File: rtl/tx_pkg.sv
// tx_pkg: shared definitions for the TX bit-serializer slice.
//   - default TOD counter widths and load/launch slot positions
//   - tx_state_e: serializer control states
package tx_pkg;

    localparam int TODH_W_DEF     = 21;
    localparam int TODL_W_DEF     = 11;
    localparam int LOAD_SLOT_DEF  = 400;
    localparam int START_SLOT_DEF = 512;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/tx_chip_timer.sv
// tx_chip_timer: modulo-CHIP_CNT counter that paces one transmitted bit.
// Ports:
//   clk, rst    clock / synchronous active-high reset
//   clear       forces the count back to zero (burst launch)
//   enable      counts while high
//   first_chip  high on the first clock of a bit (count == 0, enabled)
//   last_chip   high on the last clock of a bit (count == CHIP_CNT-1, enabled)
module tx_chip_timer
    import tx_pkg::*;
#(
    parameter int CHIP_CNT = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic first_chip,
    output logic last_chip
);

    localparam int CW = (CHIP_CNT > 1) ? $clog2(CHIP_CNT) : 1;

    logic [CW-1:0] chip_cnt;

    assign first_chip = enable && (chip_cnt == '0);
    assign last_chip  = enable && (chip_cnt == CW'(CHIP_CNT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            chip_cnt <= '0;
        end else if (enable) begin
            chip_cnt <= last_chip ? '0 : chip_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tx_bit_serializer.sv
// tx_bit_serializer: TOD-slotted bit serializer for the frequency-hopping TX path.
// Once per hop the word addressed by tod_h is captured at tod_l == LOAD_SLOT and,
// from tod_l == START_SLOT, shifted out on bit_out for exactly WORD_W bits of
// CHIP_CNT clocks each.
// Ports:
//   clk, rst       clock / synchronous active-high reset
//   tod_h, tod_l   hop index / clock count within hop
//   fh_num         number of valid hops (tod_h >= fh_num is silent)
//   tx_en          load/launch enable, looked at only on the two slots
//   msb_first      bit order, latched with the word
//   data_ram_addr  hop-data RAM address (tod_h low bits)
//   data_ram_data  hop-data RAM read data
//   bit_out        serial data, 0 outside a burst
//   bit_valid      high while bit_out carries a bit
//   bit_strobe     pulse on the first clock of each bit
//   data_reg       word captured this hop (unshifted)
//   data_reg_en    pulse on the cycle after a capture
//   busy           high while shifting
//   overrun        sticky: a slot arrived while shifting
module tx_bit_serializer
    import tx_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int TODH_W     = TODH_W_DEF,
    parameter int TODL_W     = TODL_W_DEF,
    parameter int CHIP_CNT   = 20,
    parameter int LOAD_SLOT  = LOAD_SLOT_DEF,
    parameter int START_SLOT = START_SLOT_DEF,
    parameter int RAM_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TODH_W-1:0] tod_h,
    input  logic [TODL_W-1:0] tod_l,
    input  logic [TODH_W-1:0] fh_num,
    input  logic              tx_en,
    input  logic              msb_first,
    output logic [ADDR_W-1:0] data_ram_addr,
    input  logic [WORD_W-1:0] data_ram_data,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              bit_strobe,
    output logic [WORD_W-1:0] data_reg,
    output logic              data_reg_en,
    output logic              busy,
    output logic              overrun
);

    localparam int BCW = $clog2(WORD_W + 1);

    if (START_SLOT + WORD_W * CHIP_CNT > 2 ** TODL_W) begin : g_chk_burst_fits
        $error("burst does not fit in one hop");
    end
    if (LOAD_SLOT >= START_SLOT) begin : g_chk_slot_order
        $error("LOAD_SLOT must precede START_SLOT");
    end
    if (LOAD_SLOT < RAM_LAT) begin : g_chk_ram_lat
        $error("LOAD_SLOT earlier than RAM latency");
    end
    if (CHIP_CNT < 2) begin : g_chk_chip
        $error("CHIP_CNT must be at least 2");
    end

    tx_state_e         state, state_nxt;
    logic              hop_ok, at_load, at_start;
    logic              do_load, do_launch;
    logic              first_chip, last_chip, last_bit;
    logic              loaded, msb_lat;
    logic [WORD_W-1:0] shreg;
    logic [BCW-1:0]    bit_cnt;

    assign data_ram_addr = tod_h[ADDR_W-1:0];

    assign hop_ok    = (tod_h < fh_num) && tx_en;
    assign at_load   = (tod_l == TODL_W'(LOAD_SLOT));
    assign at_start  = (tod_l == TODL_W'(START_SLOT));
    assign do_load   = (state == IDLE) && at_load && hop_ok;
    assign do_launch = (state == IDLE) && at_start && hop_ok && loaded;
    assign last_bit  = (bit_cnt == BCW'(WORD_W - 1));

    tx_chip_timer #(
        .CHIP_CNT(CHIP_CNT)
    ) u_chip_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (do_launch),
        .enable    (state == SHIFT),
        .first_chip(first_chip),
        .last_chip (last_chip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (do_launch) state_nxt = SHIFT;
            SHIFT:   if (last_chip && last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from registered state, so a reset lands on them one
    // clock later without any extra gating.
    always_comb begin
        busy       = 1'b0;
        bit_valid  = 1'b0;
        bit_out    = 1'b0;
        bit_strobe = 1'b0;
        if (state == SHIFT) begin
            busy       = 1'b1;
            bit_valid  = 1'b1;
            bit_out    = msb_lat ? shreg[WORD_W-1] : shreg[0];
            bit_strobe = first_chip;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            data_reg    <= '0;
            data_reg_en <= 1'b0;
            loaded      <= 1'b0;
            msb_lat     <= 1'b0;
            bit_cnt     <= '0;
            overrun     <= 1'b0;
        end else begin
            data_reg_en <= do_load;
            if (do_load) begin
                data_reg <= data_ram_data;
                shreg    <= data_ram_data;
                msb_lat  <= msb_first;
                loaded   <= 1'b1;
            end
            if (do_launch) begin
                loaded  <= 1'b0;
                bit_cnt <= '0;
            end
            if (state == SHIFT) begin
                if (at_load || at_start) begin
                    overrun <= 1'b1;
                end
                if (last_chip) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shreg   <= msb_lat ? {shreg[WORD_W-2:0], 1'b0}
                                       : {1'b0, shreg[WORD_W-1:1]};
                end
            end
        end
    end

endmodule
